// File: rtl/datamem_responder.sv
// Byte-addressed data-memory responder: one request at a time, response LATENCY cycles after accept.
// Stalls requests (req_ready low) until the registered response is taken; rsp_valid holds under backpressure.
module datamem_responder #(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_size,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic        write;
    logic        size;
    logic [63:0] addr;
    logic [63:0] wdata;
  } req_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  req_t          req_q;
  logic          accept, exec, err;
  logic [7:0]    mem [DEPTH_BYTES];
  logic [AW-1:0] idx;
  logic [63:0]   rd_dw, rd_val;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    exec    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          exec    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);

  assign err = (req_q.addr >= 64'(DEPTH_BYTES)) ||
               (req_q.size && (req_q.addr[2:0] != 3'b000));
  assign idx = req_q.addr[AW-1:0];

  // Doubleword reads are only used when aligned, so the low 3 index bits are replaced.
  always_comb begin
    rd_dw = '0;
    for (int i = 0; i < 8; i++) begin
      rd_dw[8*i +: 8] = mem[{idx[AW-1:3], 3'(i)}];
    end
    rd_val = req_q.size ? rd_dw : {56'b0, mem[idx]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        req_q <= '{write: req_write, size: req_size, addr: req_addr, wdata: req_wdata};
      end
      if (exec) begin
        rsp_err   <= err;
        rsp_rdata <= (err || req_q.write) ? '0 : rd_val;
      end
    end
  end

  // Storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (exec && req_q.write && !err) begin
      if (req_q.size) begin
        for (int i = 0; i < 8; i++) begin
          mem[{idx[AW-1:3], 3'(i)}] <= req_q.wdata[8*i +: 8];
        end
      end else begin
        mem[idx] <= req_q.wdata[7:0];
      end
    end
  end

endmodule

// File: tb/tb_datamem_responder.sv
// Bench for datamem_responder: LATENCY=3 instance against a transaction-level model, plus a LATENCY=1 instance for back-to-back traffic.
module tb_datamem_responder;

  localparam int DEPTH = 1024;
  localparam int L3    = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_write = 1'b0, req_size = 1'b0, rsp_ready = 1'b1;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;

  logic        b_req_valid = 1'b0, b_req_write = 1'b0, b_req_size = 1'b0;
  logic [63:0] b_req_addr = '0, b_req_wdata = '0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [63:0] b_rsp_rdata;

  datamem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(L3)) u3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  datamem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_size(b_req_size), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting, required the event within budget at t=%0t", name, $time);
  endtask

  function automatic logic [63:0] fill(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0]};
  endfunction

  // Transaction-level model of the LATENCY=3 instance.
  logic [7:0]  mm [DEPTH];
  bit          m_out = 1'b0, m_exe = 1'b0;
  int          m_wait = 0, m_acc = 0, m_done = 0;
  logic        m_w, m_s, m_err = 1'b0;
  logic [63:0] m_a, m_d, m_rdata = '0;

  function automatic logic [63:0] mm_dw(input int base);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = mm[base + i];
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_out = 1'b0; m_exe = 1'b0; m_rdata = '0; m_err = 1'b0; m_wait = 0;
      end else if (m_out && m_exe) begin
        if (rsp_ready) begin
          m_out = 1'b0; m_exe = 1'b0; m_done++;
        end
      end else if (m_out) begin
        m_wait--;
        if (m_wait == 0) begin
          m_exe = 1'b1;
          if (m_a >= 64'(DEPTH) || (m_s && m_a[2:0] != 3'b000)) begin
            m_err = 1'b1; m_rdata = '0;
          end else begin
            int ai;
            ai = int'(m_a[9:0]);
            m_err = 1'b0;
            if (m_w) begin
              if (m_s) for (int i = 0; i < 8; i++) mm[ai + i] = m_d[8*i +: 8];
              else mm[ai] = m_d[7:0];
              m_rdata = '0;
            end else begin
              m_rdata = m_s ? mm_dw(ai) : {56'b0, mm[ai]};
            end
          end
        end
      end else if (req_valid) begin
        m_w = req_write; m_s = req_size; m_a = req_addr; m_d = req_wdata;
        m_out = 1'b1; m_wait = L3; m_acc++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk1("rsp_valid", rsp_valid, m_exe);
      chk1("req_ready", req_ready, !m_out);
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk1("rsp_err", rsp_err, m_err);
    end
  end

  task automatic issue(input logic w, input logic s, input logic [63:0] a, input logic [63:0] d);
    int c0, n;
    c0 = m_acc; n = 0;
    req_valid = 1'b1; req_write = w; req_size = s; req_addr = a; req_wdata = d;
    while (m_acc == c0 && n < 40) begin @(negedge clk); n++; end
    if (m_acc == c0) timeout_fail("accept");
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 1'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
  endtask

  task automatic finish_rsp(output logic [63:0] rd, output logic er, output int lat);
    int c0, n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (rsp_valid !== 1'b1) timeout_fail("rsp_valid");
    lat = n; rd = rsp_rdata; er = rsp_err;
    c0 = m_done; n = 0;
    while (m_done == c0 && n < 40) begin @(negedge clk); n++; end
    if (m_done == c0) timeout_fail("handshake");
  endtask

  task automatic xfer(input logic w, input logic s, input logic [63:0] a, input logic [63:0] d,
                      output logic [63:0] rd, output logic er, output int lat);
    issue(w, s, a, d);
    finish_rsp(rd, er, lat);
  endtask

  logic        bw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic        bs [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [63:0] ba [4] = '{64'h40, 64'h40, 64'h43, 64'h43};
  logic [63:0] bd [4] = '{64'h1111_2222_3333_4444, 64'h0, 64'hFFFF_FFFF_FFFF_FF5A, 64'h0};
  logic [63:0] be [4] = '{64'h0, 64'h1111_2222_3333_4444, 64'h0, 64'h5A};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required finish before t=200000");
    $fatal(1);
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat;

    repeat (2) @(negedge clk);
    chk1("reset_rsp_valid", rsp_valid, 1'b0);
    chk1("reset_req_ready", req_ready, 1'b1);
    chk("reset_rsp_rdata", rsp_rdata, 64'h0);
    chk1("reset_rsp_err", rsp_err, 1'b0);
    reset = 1'b0;

    // LATENCY=1 instance, rsp_ready tied high, req_valid held high with garbage while not IDLE.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk1("b2b_req_ready", b_req_ready, (k % 3) == 0);
      chk1("b2b_rsp_valid", b_rsp_valid, (k % 3) == 2);
      if ((k % 3) == 2) begin
        chk("b2b_rdata", b_rsp_rdata, be[k/3]);
        chk1("b2b_err", b_rsp_err, 1'b0);
      end
      b_req_valid = 1'b1;
      if ((k % 3) == 0) begin
        b_req_write = bw[k/3]; b_req_size = bs[k/3]; b_req_addr = ba[k/3]; b_req_wdata = bd[k/3];
      end else begin
        b_req_write = 1'($urandom); b_req_size = 1'($urandom);
        b_req_addr = {$urandom, $urandom}; b_req_wdata = {$urandom, $urandom};
      end
    end
    b_req_valid = 1'b0;

    for (int a = 0; a < DEPTH; a += 8) xfer(1'b1, 1'b1, 64'(a), fill(64'(a)), rd, er, lat);

    // Reset two cycles into a store: store must be dropped.
    issue(1'b1, 1'b1, 64'h10, 64'hDEAD_BEEF_CAFE_F00D);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk1("midbusy_rsp_valid", rsp_valid, 1'b0);
    chk1("midbusy_req_ready", req_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    xfer(1'b0, 1'b1, 64'h10, 64'h0, rd, er, lat);
    chk("after_reset_load", rd, fill(64'h10));

    xfer(1'b1, 1'b1, 64'h20, 64'h0123_4567_89AB_CDEF, rd, er, lat);
    chk("dw_store_latency", 64'(lat), 64'(L3));
    chk("dw_store_rdata", rd, 64'h0);
    chk1("dw_store_err", er, 1'b0);
    xfer(1'b0, 1'b1, 64'h20, 64'h0, rd, er, lat);
    chk("dw_load", rd, 64'h0123_4567_89AB_CDEF);

    xfer(1'b1, 1'b0, 64'h21, 64'hAAAA_BBBB_CCCC_DDFF, rd, er, lat);
    xfer(1'b0, 1'b1, 64'h20, 64'h0, rd, er, lat);
    chk("byte_store_dw_load", rd, 64'h0123_4567_89AB_FFEF);
    xfer(1'b0, 1'b0, 64'h27, 64'h0, rd, er, lat);
    chk("byte_load", rd, 64'h1);

    xfer(1'b0, 1'b1, 64'h24, 64'h0, rd, er, lat);
    chk1("misaligned_load_err", er, 1'b1);
    chk("misaligned_load_rdata", rd, 64'h0);
    xfer(1'b1, 1'b1, 64'd1024, 64'hBADB_ADBA_DBAD_BADB, rd, er, lat);
    chk1("oob_store_err", er, 1'b1);
    xfer(1'b1, 1'b1, 64'h33, 64'hBADB_ADBA_DBAD_BADB, rd, er, lat);
    chk1("misaligned_store_err", er, 1'b1);
    xfer(1'b1, 1'b0, 64'd1027, 64'h77, rd, er, lat);
    chk1("oob_byte_store_err", er, 1'b1);

    // Backpressure with a new request waiting.
    rsp_ready = 1'b0;
    issue(1'b0, 1'b1, 64'h20, 64'h0);
    begin
      int n;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      if (rsp_valid !== 1'b1) timeout_fail("bp_rsp_valid");
    end
    req_valid = 1'b1; req_write = 1'b0; req_size = 1'b1; req_addr = 64'h8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_rdata", rsp_rdata, 64'h0123_4567_89AB_FFEF);
      chk1("bp_req_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk1("bp_release_req_ready", req_ready, 1'b1);
    req_valid = 1'b0;

    for (int a = 0; a < DEPTH; a += 8) begin
      xfer(1'b0, 1'b1, 64'(a), 64'h0, rd, er, lat);
      chk("dump", rd, mm_dw(a));
    end
    chk("dump_addr0", mm_dw(0), fill(64'h0));

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
